// File: rtl/mem_access_ctrl_pkg.sv
// Shared definitions for the memory access controller.
//  state_e : FSM state encodings (3-bit, IDLE = 0)
//  op_e    : latched transaction type (read = 0 so reset selects read)
//  MDR_SEL_MEM / MDR_SEL_BUS : MDR input mux select values
package mem_access_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ADDR    = 3'd1,
    S_RD_WAIT = 3'd2,
    S_RD_CAP  = 3'd3,
    S_WR_WAIT = 3'd4,
    S_DONE    = 3'd5,
    S_ERR     = 3'd6
  } state_e;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } op_e;

  localparam logic MDR_SEL_MEM = 1'b1;
  localparam logic MDR_SEL_BUS = 1'b0;

endpackage

// File: rtl/mem_access_ctrl_wait_timer.sv
// Wait-cycle counter for the memory access controller.
//  clk, clr : clock and synchronous active-high reset
//  clear    : force the count back to 0 (takes priority over incr)
//  incr     : advance the count by one
//  tc       : terminal count, high while the count equals TIMEOUT-1
// The controller only increments while tc is low, so the count never wraps.
module mem_access_ctrl_wait_timer #(
  parameter int TIMEOUT = 8
) (
  input  logic clk,
  input  logic clr,
  input  logic clear,
  input  logic incr,
  output logic tc
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (incr) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc = (cnt_q == CNT_LAST);

endmodule

// File: rtl/mem_access_ctrl.sv
// Memory access controller: sequences one read or write through the MAR/MDR
// pair and waits on mem_ready with a bounded timeout.
//  clk, clr          : clock and synchronous active-high reset
//  rd_req, wr_req    : transaction requests, sampled only in IDLE (read wins)
//  mem_ready         : memory completed the access (only looked at in wait states)
//  mar_en, mdr_en    : MAR / MDR load enables
//  mdr_sel           : MDR mux select, 1 = memory data, 0 = internal bus
//  mem_rd, mem_wr    : memory strobes
//  busy              : high whenever not IDLE
//  done, err         : one-cycle completion / timeout pulses
// All outputs are a Moore decode of the state and latched op.
import mem_access_ctrl_pkg::*;

module mem_access_ctrl #(
  parameter int TIMEOUT = 8
) (
  input  logic clk,
  input  logic clr,
  input  logic rd_req,
  input  logic wr_req,
  input  logic mem_ready,
  output logic mar_en,
  output logic mdr_en,
  output logic mdr_sel,
  output logic mem_rd,
  output logic mem_wr,
  output logic busy,
  output logic done,
  output logic err
);

  state_e state_q;
  state_e state_d;
  op_e    op_q;
  op_e    op_d;

  logic timer_clear;
  logic timer_incr;
  logic timer_tc;

  mem_access_ctrl_wait_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_wait_timer (
    .clk  (clk),
    .clr  (clr),
    .clear(timer_clear),
    .incr (timer_incr),
    .tc   (timer_tc)
  );

  // Next-state logic. In the wait states mem_ready is checked before the
  // timeout flag so a response on the last allowed cycle still completes.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    timer_clear = 1'b0;
    timer_incr  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (rd_req) begin
          state_d = S_ADDR;
          op_d    = OP_RD;
        end else if (wr_req) begin
          state_d = S_ADDR;
          op_d    = OP_WR;
        end
      end
      S_ADDR: begin
        timer_clear = 1'b1;
        state_d     = (op_q == OP_RD) ? S_RD_WAIT : S_WR_WAIT;
      end
      S_RD_WAIT: begin
        if (mem_ready) begin
          state_d = S_RD_CAP;
        end else if (timer_tc) begin
          state_d = S_ERR;
        end else begin
          timer_incr = 1'b1;
        end
      end
      S_RD_CAP: state_d = S_DONE;
      S_WR_WAIT: begin
        if (mem_ready) begin
          state_d = S_DONE;
        end else if (timer_tc) begin
          state_d = S_ERR;
        end else begin
          timer_incr = 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= S_IDLE;
      op_q    <= OP_RD;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
    end
  end

  // Output decode. A write loads the MDR from the bus in ADDR, alongside the
  // MAR, so the data is in place before the write strobe starts.
  always_comb begin
    mar_en  = 1'b0;
    mdr_en  = 1'b0;
    mdr_sel = MDR_SEL_BUS;
    mem_rd  = 1'b0;
    mem_wr  = 1'b0;
    busy    = (state_q != S_IDLE);
    done    = 1'b0;
    err     = 1'b0;
    case (state_q)
      S_ADDR: begin
        mar_en = 1'b1;
        if (op_q == OP_WR) begin
          mdr_en  = 1'b1;
          mdr_sel = MDR_SEL_BUS;
        end
      end
      S_RD_WAIT: mem_rd = 1'b1;
      S_RD_CAP: begin
        mdr_en  = 1'b1;
        mdr_sel = MDR_SEL_MEM;
      end
      S_WR_WAIT: mem_wr = 1'b1;
      S_DONE:    done   = 1'b1;
      S_ERR:     err    = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl (TIMEOUT = 8).
// Outputs are packed as {mar_en, mdr_en, mdr_sel, mem_rd, mem_wr, busy, done, err}
// and compared against hand-derived per-state patterns after every clock.
module tb_mem_access_ctrl;

  localparam logic [7:0] O_IDLE  = 8'h00;
  localparam logic [7:0] O_ADDRR = 8'h84;
  localparam logic [7:0] O_ADDRW = 8'hC4;
  localparam logic [7:0] O_RDW   = 8'h14;
  localparam logic [7:0] O_RDCAP = 8'h64;
  localparam logic [7:0] O_WRW   = 8'h0C;
  localparam logic [7:0] O_DONE  = 8'h06;
  localparam logic [7:0] O_ERR   = 8'h05;

  logic clk;
  logic clr;
  logic rd_req;
  logic wr_req;
  logic mem_ready;
  logic mar_en, mdr_en, mdr_sel, mem_rd, mem_wr, busy, done, err;
  logic [7:0] obs;

  int errCount;
  int checkCount;

  mem_access_ctrl #(
    .TIMEOUT(8)
  ) dut (
    .clk      (clk),
    .clr      (clr),
    .rd_req   (rd_req),
    .wr_req   (wr_req),
    .mem_ready(mem_ready),
    .mar_en   (mar_en),
    .mdr_en   (mdr_en),
    .mdr_sel  (mdr_sel),
    .mem_rd   (mem_rd),
    .mem_wr   (mem_wr),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  assign obs = {mar_en, mdr_en, mdr_sel, mem_rd, mem_wr, busy, done, err};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive inputs for the coming edge, then sample 1 time unit after it.
  task automatic applyStimulus(input logic c, input logic r, input logic w, input logic m);
    clr       = c;
    rd_req    = r;
    wr_req    = w;
    mem_ready = m;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checkCount++;
    if (got !== exp) begin
      errCount++;
      $display("[TB] FAIL %s: got %02h expected %02h", tag, got, exp);
    end
  endtask

  task automatic runVector(input string tag, input logic c, input logic r, input logic w,
                           input logic m, input logic [7:0] exp);
    applyStimulus(c, r, w, m);
    checkOutput(tag, obs, exp);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    errCount   = 0;
    checkCount = 0;
    clr = 1'b1; rd_req = 1'b0; wr_req = 1'b0; mem_ready = 1'b0;

    $display("[TB] reset held with rd_req high");
    runVector("rst0", 1, 1, 0, 0, O_IDLE);
    runVector("rst1", 1, 1, 0, 0, O_IDLE);
    runVector("rst_idle", 0, 0, 0, 0, O_IDLE);

    $display("[TB] read, ready on first wait cycle");
    runVector("rd_addr", 0, 1, 0, 0, O_ADDRR);
    runVector("rd_wait", 0, 0, 0, 1, O_RDW);
    runVector("rd_cap", 0, 0, 0, 1, O_RDCAP);
    runVector("rd_done", 0, 0, 0, 0, O_DONE);
    runVector("rd_idle", 0, 0, 0, 0, O_IDLE);

    $display("[TB] write, ready after 3 wait cycles");
    runVector("wr_addr", 0, 0, 1, 0, O_ADDRW);
    for (int i = 0; i < 4; i++) runVector($sformatf("wr_wait%0d", i), 0, 0, 0, 0, O_WRW);
    runVector("wr_done", 0, 0, 0, 1, O_DONE);
    runVector("wr_idle", 0, 0, 0, 0, O_IDLE);

    $display("[TB] read timeout");
    runVector("to_addr", 0, 1, 0, 0, O_ADDRR);
    for (int i = 0; i < 8; i++) runVector($sformatf("to_wait%0d", i), 0, 0, 0, 0, O_RDW);
    runVector("to_err", 0, 0, 0, 0, O_ERR);
    runVector("to_idle", 0, 0, 0, 0, O_IDLE);

    $display("[TB] read, ready on last allowed cycle");
    runVector("lim_addr", 0, 1, 0, 0, O_ADDRR);
    for (int i = 0; i < 8; i++) runVector($sformatf("lim_wait%0d", i), 0, 0, 0, 0, O_RDW);
    runVector("lim_cap", 0, 0, 0, 1, O_RDCAP);
    runVector("lim_done", 0, 0, 0, 0, O_DONE);
    runVector("lim_idle", 0, 0, 0, 0, O_IDLE);

    $display("[TB] simultaneous requests and requests while busy");
    runVector("both_addr", 0, 1, 1, 0, O_ADDRR);
    runVector("both_wait", 0, 0, 0, 1, O_RDW);
    runVector("busy_wr0", 0, 0, 1, 1, O_RDCAP);
    runVector("busy_wr1", 0, 0, 1, 0, O_DONE);
    runVector("busy_wr2", 0, 0, 1, 0, O_IDLE);
    runVector("busy_idle", 0, 0, 0, 0, O_IDLE);

    $display("[TB] clear during write wait, then fresh read");
    runVector("clr_addr", 0, 0, 1, 0, O_ADDRW);
    runVector("clr_wait", 0, 0, 0, 0, O_WRW);
    runVector("clr_hit", 1, 0, 0, 0, O_IDLE);
    runVector("clr_stay", 0, 0, 0, 0, O_IDLE);
    runVector("post_addr", 0, 1, 0, 1, O_ADDRR);
    runVector("post_wait", 0, 0, 0, 1, O_RDW);
    runVector("post_cap", 0, 0, 0, 1, O_RDCAP);
    runVector("post_done", 0, 0, 0, 0, O_DONE);
    runVector("post_idle", 0, 0, 0, 0, O_IDLE);

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
